nv_nvdla_mcif_write_ig_arb: RTL
===============================

Name: nv_nvdla_mcif_write_ig_arb

Overview:
- Ingress-side write scheduler for the MCIF write path.
- Arbitrates five write DMA clients (0=bdma, 1=sdp, 2=pdp, 3=cdp, 4=rbk) with weighted round-robin.
- Issues the winning request to the AXI AW/W issue stage and, in the same cycle, pushes that request's context {len, require_ack} into the per-thread context queue.
- Throttles issue against an outstanding-beat budget, which is refunded by the egress response path (eg2ig_axi_vld/eg2ig_axi_len).

Parameters:
- OS_W, 8, width of outstanding-beat counter and of reg2dp_wr_os_cnt.
- NUM_CLIENT, 5, number of write clients; fixed, not overridable.

Ports:
- nvdla_core_clk  in  1  core clock
- nvdla_core_rst  in  1  reset; one clock; reset is asynchronous and active-high
- clt_req_vld  in  5  per-client request valid, bit i = client i
- clt_req_len  in  10  per-client burst length minus 1, [2i+1:2i]
- clt_req_ack  in  5  per-client require_ack flag
- clt_req_rdy  out  5  per-client accept, one-hot or zero
- reg2dp_wr_weight  in  40  per-client weight, [8i+7:8i]; 0 treated as 1
- reg2dp_wr_os_cnt  in  OS_W  max outstanding beats; 0 blocks all issue
- out_req_vld  out  1  issue-stage valid
- out_req_rdy  in  1  issue-stage ready
- out_req_id  out  3  client id of issued request
- out_req_len  out  2  length minus 1 of issued request
- cq_wr_pvld  out  1  context-queue push valid
- cq_wr_prdy  in  5  per-thread context-queue ready
- cq_wr_thread_id  out  3  context-queue thread (= client id)
- cq_wr_pd  out  3  {len[1:0], require_ack}
- eg2ig_axi_vld  in  1  one write response retired this cycle
- eg2ig_axi_len  in  2  length minus 1 of retired burst

Behaviour:
- Reset values: out_req_vld=0, out_req_id=0, out_req_len=0, ptr=0, burst_cnt=0, os_cnt=0.
- Combinational outputs are 0 whenever no grant occurs: clt_req_rdy, cq_wr_pvld, cq_wr_thread_id, cq_wr_pd.
- Output register: a single stage (out_req_vld/id/len). It is free when !out_req_vld or out_req_rdy. It holds its value while out_req_vld & !out_req_rdy.
- Eligibility: client i is eligible when clt_req_vld[i] & cq_wr_prdy[i] & (os_cnt + clt_req_len[i] + 1 <= reg2dp_wr_os_cnt). The comparison is done at OS_W+1 bits with no wrap.
- Grant condition: output register free and at least one eligible client.
- Winner: the first eligible client scanning ptr, ptr+1, ... modulo 5.
- Grant cycle actions (all combinational, same cycle):
  - clt_req_rdy[k]=1.
  - cq_wr_pvld=1, cq_wr_thread_id=k, cq_wr_pd={len_k, ack_k}.
  - Output register loads id=k, len=len_k on the next edge.
- Latency: request accepted in cycle N, out_req_vld asserted in cycle N+1.
- No grant but register drained (out_req_rdy): out_req_vld goes to 0 next cycle.
- Weighted round-robin, applied on grant to k with weight w_k = max(weight_k, 1):
  - n = (k==ptr) ? burst_cnt+1 : 1.
  - If n >= w_k: ptr <= (k+1) mod 5, burst_cnt <= 0.
  - Else: ptr <= k, burst_cnt <= n.
  - With no grant, ptr and burst_cnt hold.
- Outstanding counter: os_cnt_next = os_cnt + (grant ? len_k+1 : 0) - (eg2ig_axi_vld ? eg2ig_axi_len+1 : 0).
  - A grant and a refund in the same cycle are both applied.
  - The refund is not visible to eligibility until the next cycle.
  - Underflow is illegal; sim assertion fires on it, and os_cnt saturates at 0.
- Config changes:
  - Lowering reg2dp_wr_os_cnt below os_cnt only blocks new grants; nothing in flight is dropped.
  - Weight changes take effect at the next grant evaluation.
- Reset mid-operation: all state clears immediately (asynchronous). Any request held in the output register is discarded, and os_cnt returns to 0.
- Illegal input: clt_req_len is sampled only when clt_req_vld is 1. A sim assertion checks no X on clt_req_vld or eg2ig_axi_vld outside reset.

Test Plan:
- Weights all 1, all 5 clients request continuously, out_req_rdy=1, os budget 255 -> grant order 0,1,2,3,4,0,... with one grant per cycle and out_req_id following one cycle later.
- Weights client0=3, client1=1, others idle, both requesting -> id sequence 0,0,0,1,0,0,0,1; burst_cnt resets to 0 after every switch.
- reg2dp_wr_os_cnt=4, client2 len=3 (4 beats) requesting back-to-back, no responses -> exactly one grant, then stall. Inject eg2ig_axi_vld with len=3 -> os_cnt returns to 0 and the next grant comes one cycle later.
- out_req_rdy=0 for 3 cycles with the register full -> out_req_id/len held stable and clt_req_rdy=0 throughout. Raise out_req_rdy -> grant occurs in that same cycle.
- cq_wr_prdy[1]=0 while clients 1 and 3 request and ptr=1 -> client 3 granted; cq_wr_thread_id=3 and cq_wr_pd={len3, ack3}.
- Assert reset while out_req_vld=1 and os_cnt=7 -> out_req_vld=0, os_cnt=0, ptr=0 immediately without waiting for a clock edge. After release, the first grant goes to client 0 when it requests.

Source files
------------

// File: rtl/nv_nvdla_mcif_write_ig_arb.sv
// rtl/nv_nvdla_mcif_write_ig_arb.sv - MCIF write ingress weighted round-robin arbiter with outstanding-beat throttle
module nv_nvdla_mcif_write_ig_arb #(
   parameter int OS_W = 8
) (
   input  logic             nvdla_core_clk,
   input  logic             nvdla_core_rst,
   input  logic [4:0]       clt_req_vld,
   input  logic [9:0]       clt_req_len,
   input  logic [4:0]       clt_req_ack,
   output logic [4:0]       clt_req_rdy,
   input  logic [39:0]      reg2dp_wr_weight,
   input  logic [OS_W-1:0]  reg2dp_wr_os_cnt,
   output logic             out_req_vld,
   input  logic             out_req_rdy,
   output logic [2:0]       out_req_id,
   output logic [1:0]       out_req_len,
   output logic             cq_wr_pvld,
   input  logic [4:0]       cq_wr_prdy,
   output logic [2:0]       cq_wr_thread_id,
   output logic [2:0]       cq_wr_pd,
   input  logic             eg2ig_axi_vld,
   input  logic [1:0]       eg2ig_axi_len
);
   localparam int NUM_CLIENT = 5;

   logic [2:0]      ptr_q, ptr_d;
   logic [7:0]      burst_cnt_q, burst_cnt_d;
   logic [OS_W-1:0] os_cnt_q, os_cnt_d;
   logic            out_vld_q, out_vld_d;
   logic [2:0]      out_id_q, out_id_d;
   logic [1:0]      out_len_q, out_len_d;

   logic [NUM_CLIENT-1:0] elig;
   logic            found, grant, reg_free, os_underflow;
   logic [2:0]      win, idx;
   logic [3:0]      scan;
   logic [1:0]      win_len;
   logic            win_ack;
   logic [7:0]      win_weight;
   logic [8:0]      burst_n;
   logic [OS_W:0]   os_sum, os_sub, os_diff;

   // Burst length minus one expanded to a beat count at OS_W+1 bits, so budget compares never wrap.
   function automatic logic [OS_W:0] beats(input logic [1:0] len);
      return {{(OS_W-1){1'b0}}, len} + {{OS_W{1'b0}}, 1'b1};
   endfunction

   always_comb begin
      for (int i = 0; i < NUM_CLIENT; i++) begin
         elig[i] = clt_req_vld[i] & cq_wr_prdy[i] &
                   (({1'b0, os_cnt_q} + beats(clt_req_len[2*i +: 2])) <= {1'b0, reg2dp_wr_os_cnt});
      end
   end

   always_comb begin
      found = 1'b0;
      win   = 3'd0;
      scan  = 4'd0;
      idx   = 3'd0;
      for (int off = 0; off < NUM_CLIENT; off++) begin
         scan = {1'b0, ptr_q} + 4'(off);
         if (scan >= 4'd5) scan = scan - 4'd5;
         idx = scan[2:0];
         if (!found && elig[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   assign reg_free   = !out_vld_q || out_req_rdy;
   assign grant      = reg_free && found;
   assign win_len    = clt_req_len[{win, 1'b0} +: 2];
   assign win_ack    = clt_req_ack[win];
   assign win_weight = (reg2dp_wr_weight[{win, 3'b000} +: 8] == 8'd0) ? 8'd1
                                                                      : reg2dp_wr_weight[{win, 3'b000} +: 8];
   assign burst_n    = (win == ptr_q) ? ({1'b0, burst_cnt_q} + 9'd1) : 9'd1;

   always_comb begin
      ptr_d       = ptr_q;
      burst_cnt_d = burst_cnt_q;
      if (grant) begin
         if (burst_n >= {1'b0, win_weight}) begin
            ptr_d       = (win == 3'd4) ? 3'd0 : win + 3'd1;
            burst_cnt_d = 8'd0;
         end else begin
            ptr_d       = win;
            burst_cnt_d = burst_n[7:0];
         end
      end
   end

   // A same-cycle refund is folded in here only, so eligibility sees it one cycle later.
   assign os_sum       = {1'b0, os_cnt_q} + (grant ? beats(win_len) : '0);
   assign os_sub       = eg2ig_axi_vld ? beats(eg2ig_axi_len) : '0;
   assign os_underflow = os_sub > os_sum;
   assign os_diff      = os_sum - os_sub;
   assign os_cnt_d     = os_underflow ? '0 : os_diff[OS_W-1:0];

   always_comb begin
      out_vld_d = out_vld_q;
      out_id_d  = out_id_q;
      out_len_d = out_len_q;
      if (grant) begin
         out_vld_d = 1'b1;
         out_id_d  = win;
         out_len_d = win_len;
      end else if (reg_free) begin
         out_vld_d = 1'b0;
      end
   end

   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         ptr_q       <= 3'd0;
         burst_cnt_q <= 8'd0;
         os_cnt_q    <= '0;
         out_vld_q   <= 1'b0;
         out_id_q    <= 3'd0;
         out_len_q   <= 2'd0;
      end else begin
         ptr_q       <= ptr_d;
         burst_cnt_q <= burst_cnt_d;
         os_cnt_q    <= os_cnt_d;
         out_vld_q   <= out_vld_d;
         out_id_q    <= out_id_d;
         out_len_q   <= out_len_d;
      end
   end

   always_comb begin
      clt_req_rdy     = grant ? (5'b00001 << win) : 5'b00000;
      cq_wr_pvld      = grant;
      cq_wr_thread_id = grant ? win : 3'd0;
      cq_wr_pd        = grant ? {win_len, win_ack} : 3'd0;
      out_req_vld     = out_vld_q;
      out_req_id      = out_id_q;
      out_req_len     = out_len_q;
   end

   a_no_underflow: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst) !os_underflow);
   a_no_x_vld: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
                                !$isunknown({clt_req_vld, eg2ig_axi_vld}));

endmodule
